// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared definitions for the UART receiver slice.
//   state_t     - receiver FSM state encoding
//   DATA_BITS   - data bits per 8N1 frame
//   SYNC_STAGES - flops in the asynchronous-pin synchronizer
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    localparam int unsigned DATA_BITS   = 8;
    localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: byte/valid output bundle of the UART receiver, consumed by the
// downstream FIFO control stage.
//   rx_dv        - one-cycle pulse, rx_byte holds a newly received byte
//   rx_byte      - last valid byte, held between pulses
//   rx_frame_err - one-cycle pulse, stop bit sampled low, frame discarded
// Modports: master = receiver side (drives), slave = consumer side.
interface uart_rx_if;

    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       rx_frame_err;

    modport master (output rx_dv, output rx_byte, output rx_frame_err);
    modport slave  (input  rx_dv, input  rx_byte, input  rx_frame_err);

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// sync_2ff: flop-chain synchronizer for an asynchronous input pin.
//   clk       - destination clock
//   rst       - asynchronous active-high reset, chain loads RESET_VAL
//   d         - asynchronous input
//   q         - synchronized output (SYNC_STAGES cycles of latency)
module sync_2ff
    import uart_rx_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver. Recovers frames from the asynchronous serial
// line, delivers valid bytes with a one-cycle strobe, flags bad stop bits.
//   CLKS_PER_BIT - clock cycles per bit (4..65535)
//   i_Clock      - system clock, rising edge
//   i_Reset      - asynchronous active-high reset
//   i_Rx_Serial  - raw serial line, idle high
//   rx_out       - byte/valid/frame-error bundle (uart_rx_if.master)
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 87
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_Serial,
    uart_rx_if.master  rx_out
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_IDX = 3'(DATA_BITS - 1);

    logic          rx_s;
    state_t        state, state_n;
    logic [CW-1:0] count, count_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shift, shift_n;
    logic [7:0]    byte_q, byte_n;
    logic          dv_q, dv_n;
    logic          err_q, err_n;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start.
    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk (i_Clock),
        .rst (i_Reset),
        .d   (i_Rx_Serial),
        .q   (rx_s)
    );

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state  <= IDLE;
            count  <= '0;
            idx    <= '0;
            shift  <= '0;
            byte_q <= '0;
            dv_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_n;
            count  <= count_n;
            idx    <= idx_n;
            shift  <= shift_n;
            byte_q <= byte_n;
            dv_q   <= dv_n;
            err_q  <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        count_n = count;
        idx_n   = idx;
        shift_n = shift;
        byte_n  = byte_q;
        dv_n    = 1'b0;
        err_n   = 1'b0;

        case (state)
            IDLE: begin
                count_n = '0;
                if (!rx_s) begin
                    state_n = START;
                end
            end

            // Re-check the start bit near its middle; a high there was a glitch.
            START: begin
                if (count == HALF_CNT) begin
                    count_n = '0;
                    if (!rx_s) begin
                        idx_n   = '0;
                        state_n = DATA;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    count_n = count + 1'b1;
                end
            end

            DATA: begin
                if (count == LAST_CNT) begin
                    count_n      = '0;
                    shift_n[idx] = rx_s;
                    if (idx == LAST_IDX) begin
                        state_n = STOP;
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end else begin
                    count_n = count + 1'b1;
                end
            end

            // Returning to IDLE mid-stop-bit lets a back-to-back start bit be seen.
            STOP: begin
                if (count == LAST_CNT) begin
                    count_n = '0;
                    if (rx_s) begin
                        byte_n  = shift;
                        dv_n    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        err_n   = 1'b1;
                        state_n = WAIT_HIGH;
                    end
                end else begin
                    count_n = count + 1'b1;
                end
            end

            // Held-low line (break) must not be decoded as further frames.
            WAIT_HIGH: begin
                if (rx_s) begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign rx_out.rx_dv        = dv_q;
    assign rx_out.rx_byte      = byte_q;
    assign rx_out.rx_frame_err = err_q;

endmodule
